butterfly_dif: RTL and testbench

- Radix-2 decimation-in-frequency butterfly: the dual of the team's DIT butterfly.
  - y0 = x0 + x1
  - y1 = (x0 - x1) * W
- Used by the inverse/DIF path of the 16-point FFT engine.
- Carries an `inverse` flag per sample that conjugates the twiddle, so one instance serves both FFT and IFFT.
- Fully pipelined, with valid/ready flow control so downstream stages can stall it.

---
 rtl/butterfly_dif.sv | 156 +++++++++++++++
 tb/tb_butterfly_dif.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/butterfly_dif.sv
// Radix-2 DIF butterfly, 4-stage valid/ready pipeline: y0 = x0 + x1, y1 = (x0 - x1) * W (or conj(W)).
// Define BUTTERFLY_DIF_SAT_EN for output saturation plus sticky ovf; otherwise outputs wrap and ovf is 0.
module butterfly_dif #(
  parameter int DATA_WIDTH  = 20,
  parameter int SCALE_SHIFT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  inverse,
  input  logic [DATA_WIDTH-1:0] x0_real,
  input  logic [DATA_WIDTH-1:0] x0_imag,
  input  logic [DATA_WIDTH-1:0] x1_real,
  input  logic [DATA_WIDTH-1:0] x1_imag,
  input  logic [DATA_WIDTH-1:0] twiddle_real,
  input  logic [DATA_WIDTH-1:0] twiddle_imag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] y0_real,
  output logic [DATA_WIDTH-1:0] y0_imag,
  output logic [DATA_WIDTH-1:0] y1_real,
  output logic [DATA_WIDTH-1:0] y1_imag,
  input  logic                  ovf_clr,
  output logic                  ovf
);

  localparam int DW  = DATA_WIDTH;
  localparam int SW  = DW + 1;
  localparam int PW1 = 2*DW + 2;
  localparam int PW2 = 2*DW + 3;
  localparam int PW  = 2*DW + 4;
  localparam logic signed [PW-1:0] RND = PW'(1) << (DW - 2 + SCALE_SHIFT);

  logic en;

  logic              s1_v_q, s1_v_d;
  logic signed [SW-1:0] s1_sum_r_q, s1_sum_i_q, s1_diff_r_q, s1_diff_i_q, s1_wr_q, s1_wi_q;
  logic signed [SW-1:0] s1_sum_r_d, s1_sum_i_d, s1_diff_r_d, s1_diff_i_d, s1_wr_d, s1_wi_d;

  logic              s2_v_q;
  logic signed [SW-1:0]  s2_sum_r_q, s2_sum_i_q;
  logic signed [PW1-1:0] p1_q, p2_q, p3_q, p4_q, p1_d, p2_d, p3_d, p4_d;

  logic              s3_v_q;
  logic signed [SW-1:0]  s3_sum_r_q, s3_sum_i_q;
  logic signed [PW2-1:0] pr_q, pi_q, pr_d, pi_d;

  logic              out_valid_q, ovf_q, ovf_d, ovf_ev;
  logic [DW-1:0]     y0r_q, y0i_q, y1r_q, y1i_q;
  logic [DW:0]       f0r, f0i, f1r, f1i;

  function automatic logic signed [SW-1:0] sx1(input logic [DW-1:0] v);
    return {v[DW-1], v};
  endfunction

  function automatic logic signed [PW1-1:0] sx2(input logic signed [SW-1:0] v);
    return {{(PW1-SW){v[SW-1]}}, v};
  endfunction

  // Returns {overflow, reduced value}; reduction wraps unless saturation is built in.
  function automatic logic [DW:0] fit(input logic signed [PW-1:0] v);
    logic          ov;
    logic [DW-1:0] r;
    ov = (|v[PW-1:DW-1]) && !(&v[PW-1:DW-1]);
    r  = v[DW-1:0];
`ifdef BUTTERFLY_DIF_SAT_EN
    if (ov) r = v[PW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
    return {ov, r};
  endfunction

  assign en       = !out_valid_q | out_ready;
  assign in_ready = en;

  always_comb begin
    s1_v_d      = in_valid;
    s1_sum_r_d  = sx1(x0_real) + sx1(x1_real);
    s1_sum_i_d  = sx1(x0_imag) + sx1(x1_imag);
    s1_diff_r_d = sx1(x0_real) - sx1(x1_real);
    s1_diff_i_d = sx1(x0_imag) - sx1(x1_imag);
    s1_wr_d     = sx1(twiddle_real);
    // Widened first so negating -1.0 stays exact
    s1_wi_d     = inverse ? -sx1(twiddle_imag) : sx1(twiddle_imag);
  end

  always_comb begin
    p1_d = sx2(s1_diff_r_q) * sx2(s1_wr_q);
    p2_d = sx2(s1_diff_i_q) * sx2(s1_wi_q);
    p3_d = sx2(s1_diff_r_q) * sx2(s1_wi_q);
    p4_d = sx2(s1_diff_i_q) * sx2(s1_wr_q);
    pr_d = {p1_q[PW1-1], p1_q} - {p2_q[PW1-1], p2_q};
    pi_d = {p3_q[PW1-1], p3_q} + {p4_q[PW1-1], p4_q};
  end

  always_comb begin
    logic signed [PW-1:0] w0r, w0i, w1r, w1i;
    w0r = {{(PW-SW){s3_sum_r_q[SW-1]}}, s3_sum_r_q};
    w0i = {{(PW-SW){s3_sum_i_q[SW-1]}}, s3_sum_i_q};
    w1r = {pr_q[PW2-1], pr_q} + RND;
    w1i = {pi_q[PW2-1], pi_q} + RND;
    f0r = fit(w0r >>> SCALE_SHIFT);
    f0i = fit(w0i >>> SCALE_SHIFT);
    f1r = fit(w1r >>> (DW - 1 + SCALE_SHIFT));
    f1i = fit(w1i >>> (DW - 1 + SCALE_SHIFT));
    ovf_ev = s3_v_q & en & (f0r[DW] | f0i[DW] | f1r[DW] | f1i[DW]);
`ifdef BUTTERFLY_DIF_SAT_EN
    ovf_d = (ovf_q & !ovf_clr) | ovf_ev;
`else
    ovf_d = 1'b0;
`endif
  end

`ifndef BUTTERFLY_DIF_SAT_EN
  logic unused_ovf;
  assign unused_ovf = ^{ovf_clr, ovf_ev};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0; s2_v_q <= 1'b0; s3_v_q <= 1'b0; out_valid_q <= 1'b0;
      s1_sum_r_q <= '0; s1_sum_i_q <= '0; s1_diff_r_q <= '0; s1_diff_i_q <= '0;
      s1_wr_q <= '0; s1_wi_q <= '0;
      s2_sum_r_q <= '0; s2_sum_i_q <= '0;
      p1_q <= '0; p2_q <= '0; p3_q <= '0; p4_q <= '0;
      s3_sum_r_q <= '0; s3_sum_i_q <= '0; pr_q <= '0; pi_q <= '0;
      y0r_q <= '0; y0i_q <= '0; y1r_q <= '0; y1i_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      if (en) begin
        s1_v_q      <= s1_v_d;
        s1_sum_r_q  <= s1_sum_r_d;  s1_sum_i_q  <= s1_sum_i_d;
        s1_diff_r_q <= s1_diff_r_d; s1_diff_i_q <= s1_diff_i_d;
        s1_wr_q     <= s1_wr_d;     s1_wi_q     <= s1_wi_d;
        s2_v_q      <= s1_v_q;
        s2_sum_r_q  <= s1_sum_r_q;  s2_sum_i_q  <= s1_sum_i_q;
        p1_q <= p1_d; p2_q <= p2_d; p3_q <= p3_d; p4_q <= p4_d;
        s3_v_q      <= s2_v_q;
        s3_sum_r_q  <= s2_sum_r_q;  s3_sum_i_q  <= s2_sum_i_q;
        pr_q <= pr_d; pi_q <= pi_d;
        out_valid_q <= s3_v_q;
        y0r_q <= f0r[DW-1:0]; y0i_q <= f0i[DW-1:0];
        y1r_q <= f1r[DW-1:0]; y1i_q <= f1i[DW-1:0];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign y0_real   = y0r_q;
  assign y0_imag   = y0i_q;
  assign y1_real   = y1r_q;
  assign y1_imag   = y1i_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_butterfly_dif.sv
// Directed bench for butterfly_dif: latency, conjugation, backpressure, overflow, scaling, reset.
module tb_butterfly_dif;

  logic clk = 1'b0;
  logic rst_n, in_valid, inverse, out_ready, ovf_clr;
  logic signed [19:0] x0_real, x0_imag, x1_real, x1_imag, twiddle_real, twiddle_imag;
  logic in_ready, out_valid, ovf;
  logic signed [19:0] y0_real, y0_imag, y1_real, y1_imag;
  logic in_ready_s, out_valid_s, ovf_s;
  logic signed [19:0] ys0_real, ys0_imag, ys1_real, ys1_imag;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  butterfly_dif #(.DATA_WIDTH(20), .SCALE_SHIFT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .inverse(inverse),
    .x0_real(x0_real), .x0_imag(x0_imag), .x1_real(x1_real), .x1_imag(x1_imag),
    .twiddle_real(twiddle_real), .twiddle_imag(twiddle_imag),
    .out_valid(out_valid), .out_ready(out_ready),
    .y0_real(y0_real), .y0_imag(y0_imag), .y1_real(y1_real), .y1_imag(y1_imag),
    .ovf_clr(ovf_clr), .ovf(ovf));

  butterfly_dif #(.DATA_WIDTH(20), .SCALE_SHIFT(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .inverse(inverse),
    .x0_real(x0_real), .x0_imag(x0_imag), .x1_real(x1_real), .x1_imag(x1_imag),
    .twiddle_real(twiddle_real), .twiddle_imag(twiddle_imag),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .y0_real(ys0_real), .y0_imag(ys0_imag), .y1_real(ys1_real), .y1_imag(ys1_imag),
    .ovf_clr(ovf_clr), .ovf(ovf_s));

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int a_r, input int a_i, input int b_r, input int b_i,
                        input int w_r, input int w_i, input logic inv);
    x0_real = 20'(a_r); x0_imag = 20'(a_i);
    x1_real = 20'(b_r); x1_imag = 20'(b_i);
    twiddle_real = 20'(w_r); twiddle_imag = 20'(w_i);
    inverse = inv;
  endtask

  task automatic send(input int a_r, input int a_i, input int b_r, input int b_i,
                      input int w_r, input int w_i, input logic inv);
    set_in(a_r, a_i, b_r, b_i, w_r, w_i, inv);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Call right after send(): output must appear on the 4th edge counting the capture edge.
  task automatic latency_check(input string tag);
    repeat (2) begin
      tick();
      check({tag, "_early"}, int'(out_valid), 0);
    end
    tick();
    check({tag, "_valid"}, int'(out_valid), 1);
  endtask

  localparam int NEG1 = 32'h80000;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int exp_v[6];
    int sent, got, stall_left, held, cyc;
    logic stall_done, xin, xout;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 1'b0);
    #3;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_y0r", int'(y0_real), 0);
    check("rst_in_ready", int'(in_ready), 1);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // basic result and latency
    send(1000, 200, 400, -100, NEG1, 0, 1'b0);
    latency_check("t1");
    check("t1_y0r", int'(y0_real), 1400);
    check("t1_y0i", int'(y0_imag), 100);
    check("t1_y1r", int'(y1_real), -600);
    check("t1_y1i", int'(y1_imag), -300);
    tick();
    check("t1_single", int'(out_valid), 0);

    // conjugation with back-to-back samples, W = -j
    set_in(1000, 200, 400, -100, 0, NEG1, 1'b0);
    in_valid = 1'b1;
    tick();
    inverse = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    check("t2a_valid", int'(out_valid), 1);
    check("t2a_y1r", int'(y1_real), 300);
    check("t2a_y1i", int'(y1_imag), -600);
    check("t2a_y0r", int'(y0_real), 1400);
    tick();
    check("t2b_valid", int'(out_valid), 1);
    check("t2b_y1r", int'(y1_real), -300);
    check("t2b_y1i", int'(y1_imag), 600);
    check("t2b_y0i", int'(y0_imag), 100);
    tick();

    // backpressure: 6 samples, 3-cycle stall when first output appears
    for (int k = 0; k < 6; k++) exp_v[k] = 100 * (k + 1) + 7;
    sent = 0; got = 0; stall_left = 0; held = 0; cyc = 0; stall_done = 1'b0;
    while (got < 6 && cyc < 60) begin
      if (out_valid && !stall_done) begin
        stall_left = 3; stall_done = 1'b1; held = int'(y0_real);
      end
      out_ready = (stall_left == 0);
      in_valid = (sent < 6);
      set_in(100 * (sent + 1) + 7, 0, 0, 0, NEG1, 0, 1'b0);
      #1;
      if (stall_left > 0) check("bp_in_ready", int'(in_ready), 0);
      if (stall_left > 0 && stall_left < 3) begin
        check("bp_hold_y0", int'(y0_real), held);
        check("bp_hold_valid", int'(out_valid), 1);
      end
      xin = in_valid && in_ready;
      xout = out_valid && out_ready;
      if (xout) begin
        check("bp_y0r", int'(y0_real), exp_v[got]);
        check("bp_y1r", int'(y1_real), -exp_v[got]);
        got++;
      end
      @(posedge clk);
      #1;
      if (xin) sent++;
      if (stall_left > 0) stall_left--;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_got", got, 6);
    check("bp_sent", sent, 6);
    check("bp_stalled", int'(stall_done), 1);
    check("bp_no_dup", int'(out_valid), 0);
    tick();

    // overflow: y0_real = 524288 does not fit
    send(524287, 0, 1, 0, NEG1, 0, 1'b0);
    repeat (3) tick();
    check("t4_valid", int'(out_valid), 1);
    check("t4_y1r", int'(y1_real), -524286);
`ifdef BUTTERFLY_DIF_SAT_EN
    check("t4_y0r_sat", int'(y0_real), 524287);
    check("t4_ovf", int'(ovf), 1);
    repeat (2) tick();
    check("t4_ovf_sticky", int'(ovf), 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("t4_ovf_cleared", int'(ovf), 0);
    send(524287, 0, 1, 0, NEG1, 0, 1'b0);
    repeat (2) tick();
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("t4_ovf_clr_coincide", int'(ovf), 1);
`else
    check("t4_y0r_wrap", int'(y0_real), -524288);
    check("t4_ovf", int'(ovf), 0);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("t4_ovf_after_clr", int'(ovf), 0);
`endif
    tick();

    // scaling instance halves both outputs
    send(1001, 0, 0, 0, NEG1, 0, 1'b0);
    repeat (3) tick();
    check("t5_valid", int'(out_valid_s), 1);
    check("t5_y0r", int'(ys0_real), 500);
    check("t5_y0i", int'(ys0_imag), 0);
    check("t5_y1r", int'(ys1_real), -500);
    check("t5_y1i", int'(ys1_imag), 0);
    check("t5_unscaled_y1r", int'(y1_real), -1001);
    tick();

    // reset with samples in flight
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_in(3000 + k, 7, 5, 3, NEG1, 0, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("t6_pre_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", int'(out_valid), 0);
    check("t6_rst_y0r", int'(y0_real), 0);
    check("t6_rst_y1r", int'(y1_real), 0);
    check("t6_rst_ovf", int'(ovf), 0);
    tick();
    rst_n = 1'b1;
    held = 0;
    repeat (5) begin
      tick();
      if (out_valid) held++;
    end
    check("t6_no_stale", held, 0);
    send(50, 60, 10, 20, NEG1, 0, 1'b0);
    latency_check("t6");
    check("t6_y0r", int'(y0_real), 60);
    check("t6_y0i", int'(y0_imag), 80);
    check("t6_y1r", int'(y1_real), -40);
    check("t6_y1i", int'(y1_imag), -40);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
